// File: rtl/alarm_ring_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alarm_ring_ctrl
//   Sequences alarm ringing. Detects the rising edge of (running time == alarm
//   time), then walks the buzzer through RINGING, SNOOZE and timeout phases.
//   Sits between the time/alarm registers and the buzzer pin.
//
// Parameters
//   RING_SEC    seconds a ring phase lasts before auto-timeout (>=1)
//   SNOOZE_SEC  seconds of silence per snooze (>=1)
//   MAX_SNOOZE  snoozes allowed per alarm event (0..7)
//   TONE_DIV    CLK cycles per TONE half-period (>=1)
//
// Ports
//   CLK            in   system clock
//   RESET          in   asynchronous reset, active-high
//   TICK_1HZ       in   one-CLK pulse per second
//   IN_TIME        in   [17] meridian, [16:12] hour, [11:6] min, [5:0] sec
//   IN_ALARM_TIME  in   [16:12] hour, [11:6] min, [5:0] sec
//   ALARM_ENABLE   in   level, alarm armed
//   SETTING        in   level, user editing time/alarm (masks new triggers)
//   STOP_KEY       in   one-CLK pulse, stop alarm
//   SNOOZE_KEY     in   one-CLK pulse, snooze alarm
//   STATE          out  00 IDLE, 01 RINGING, 10 SNOOZE
//   BUZZ           out  1 while RINGING
//   TONE           out  square wave, active only while RINGING
//   SNOOZE_CNT     out  snoozes used in the current event
//   MISSED         out  sticky flag, alarm exhausted unanswered
// -----------------------------------------------------------------------------
module alarm_ring_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int TONE_DIV   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK_1HZ,
    input  logic [17:0] IN_TIME,
    input  logic [16:0] IN_ALARM_TIME,
    input  logic        ALARM_ENABLE,
    input  logic        SETTING,
    input  logic        STOP_KEY,
    input  logic        SNOOZE_KEY,
    output logic [1:0]  STATE,
    output logic        BUZZ,
    output logic        TONE,
    output logic [2:0]  SNOOZE_CNT,
    output logic        MISSED
);

    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam int WAIT_W = $clog2(SNOOZE_SEC + 1);
    localparam int DIV_W  = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
    localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SNOOZE_SEC);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TONE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [2:0]        SNZ_MAX   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RINGING = 2'b01,
        ST_SNOOZE  = 2'b10
    } state_t;

    state_t              state_reg,      state_next;
    logic [RING_W-1:0]   ring_cnt_reg,   ring_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt_reg,   wait_cnt_next;
    logic [2:0]          snooze_cnt_reg, snooze_cnt_next;
    logic                missed_reg,     missed_next;
    logic [DIV_W-1:0]    div_reg,        div_next;
    logic                tone_reg,       tone_next;
    logic                buzz_reg,       buzz_next;
    logic                match_d_reg;

    logic match;
    logic trigger;
    logic can_snooze;

    // The meridian bit takes no part in the comparison.
    logic unused_meridian;
    assign unused_meridian = IN_TIME[17];

    assign match      = (IN_TIME[16:0] == IN_ALARM_TIME);
    // Edge-detect so a match lasting a whole second fires only once.
    assign trigger    = match & ~match_d_reg & ALARM_ENABLE & ~SETTING;
    assign can_snooze = (snooze_cnt_reg < SNZ_MAX);

    always_comb begin
        state_next      = state_reg;
        ring_cnt_next   = ring_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        snooze_cnt_next = snooze_cnt_reg;
        missed_next     = missed_reg;
        div_next        = '0;
        tone_next       = 1'b0;
        buzz_next       = 1'b0;

        if (!ALARM_ENABLE) begin
            // Disarming overrides everything and wipes the event history.
            state_next      = ST_IDLE;
            snooze_cnt_next = 3'd0;
            missed_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_next      = ST_RINGING;
                        ring_cnt_next   = RING_LOAD;
                        snooze_cnt_next = 3'd0;
                        missed_next     = 1'b0;
                    end else if (STOP_KEY) begin
                        missed_next = 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (STOP_KEY) begin
                        state_next = ST_IDLE;
                    end else if (SNOOZE_KEY && can_snooze) begin
                        state_next      = ST_SNOOZE;
                        snooze_cnt_next = snooze_cnt_reg + 3'd1;
                        wait_cnt_next   = WAIT_LOAD;
                    end else if (TICK_1HZ) begin
                        if (ring_cnt_reg == RING_ONE) begin
                            if (can_snooze) begin
                                state_next      = ST_SNOOZE;
                                snooze_cnt_next = snooze_cnt_reg + 3'd1;
                                wait_cnt_next   = WAIT_LOAD;
                            end else begin
                                state_next  = ST_IDLE;
                                missed_next = 1'b1;
                            end
                        end else begin
                            ring_cnt_next = ring_cnt_reg - RING_ONE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (STOP_KEY) begin
                        state_next = ST_IDLE;
                    end else if (TICK_1HZ) begin
                        if (wait_cnt_reg == WAIT_ONE) begin
                            state_next    = ST_RINGING;
                            ring_cnt_next = RING_LOAD;
                        end else begin
                            wait_cnt_next = wait_cnt_reg - WAIT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        buzz_next = (state_next == ST_RINGING);

        // Tone only runs while staying in RINGING; entry or exit restarts it at 0.
        if (state_reg == ST_RINGING && state_next == ST_RINGING) begin
            if (div_reg == DIV_LAST) begin
                div_next  = '0;
                tone_next = ~tone_reg;
            end else begin
                div_next  = div_reg + DIV_ONE;
                tone_next = tone_reg;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            ring_cnt_reg   <= '0;
            wait_cnt_reg   <= '0;
            snooze_cnt_reg <= 3'd0;
            missed_reg     <= 1'b0;
            div_reg        <= '0;
            tone_reg       <= 1'b0;
            buzz_reg       <= 1'b0;
            // Treat the comparator as already matched so release cannot trigger.
            match_d_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            ring_cnt_reg   <= ring_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            snooze_cnt_reg <= snooze_cnt_next;
            missed_reg     <= missed_next;
            div_reg        <= div_next;
            tone_reg       <= tone_next;
            buzz_reg       <= buzz_next;
            match_d_reg    <= match;
        end
    end

    assign STATE      = state_reg;
    assign BUZZ       = buzz_reg;
    assign TONE       = tone_reg;
    assign SNOOZE_CNT = snooze_cnt_reg;
    assign MISSED     = missed_reg;

endmodule
